// File: rtl/enemy_spawner.sv
// enemy_spawner: obstacle slot pool with LFSR-randomised spawn gaps.
// Spawns obstacles at the right edge, moves them left on every game step,
// and retires them when they reach the left edge.
module enemy_spawner #(
    parameter int          SLOTS    = 4,
    parameter int          XW       = 10,
    parameter int          SCREEN_X = 640,
    parameter int          TW       = 2,
    parameter int          MIN_GAP  = 40,
    parameter int          GW       = 6,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  run,
    input  logic                  clear,
    input  logic [3:0]            speed,
    output logic [SLOTS-1:0]      obj_active,
    output logic [SLOTS*XW-1:0]   obj_x,
    output logic [SLOTS*TW-1:0]   obj_type,
    output logic                  spawn_pulse,
    output logic [15:0]           spawn_count
);

    // A zero seed would lock the LFSR up, so it is replaced.
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int          MGW       = $clog2(MIN_GAP + 1);
    // One extra bit so MIN_GAP + max random addend cannot overflow.
    localparam int          GAPW      = ((GW > MGW) ? GW : MGW) + 1;

    logic [SLOTS-1:0]    active_q, active_d;
    logic [SLOTS*XW-1:0] x_q, x_d;
    logic [SLOTS*TW-1:0] type_q, type_d;
    logic                pulse_q, pulse_d;
    logic [15:0]         count_q, count_d;
    logic [GAPW-1:0]     gap_q, gap_d;
    logic [15:0]         lfsr_q, lfsr_d;

    logic                step;
    logic                found;
    logic [XW-1:0]       speed_ext;

    // Next-state: LFSR free-runs; slots and gap counter change only on clear or step.
    always_comb begin
        lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        active_d  = active_q;
        x_d       = x_q;
        type_d    = type_q;
        pulse_d   = 1'b0;
        count_d   = count_q;
        gap_d     = gap_q;
        found     = 1'b0;
        step      = tick & run & ~clear;
        speed_ext = XW'(speed);

        if (clear) begin
            active_d = '0;
            x_d      = '0;
            type_d   = '0;
            gap_d    = GAPW'(MIN_GAP);
        end else if (step) begin
            // Move every live slot using pre-step state; retire instead of wrapping.
            for (int i = 0; i < SLOTS; i++) begin
                if (active_q[i]) begin
                    if (x_q[i*XW +: XW] >= speed_ext) begin
                        x_d[i*XW +: XW] = x_q[i*XW +: XW] - speed_ext;
                    end else begin
                        active_d[i]     = 1'b0;
                        x_d[i*XW +: XW] = '0;
                    end
                end
            end

            if (gap_q != '0) begin
                gap_d = gap_q - GAPW'(1);
            end else begin
                // Lowest free slot in pre-step state; a slot retiring this step is not free yet.
                for (int i = 0; i < SLOTS; i++) begin
                    if (!found && !active_q[i]) begin
                        found           = 1'b1;
                        active_d[i]     = 1'b1;
                        x_d[i*XW +: XW] = XW'(SCREEN_X);
                        type_d[i*TW +: TW] = lfsr_q[TW-1:0];
                    end
                end
                // Without a free slot the gap stays at zero and the spawn retries next step.
                if (found) begin
                    gap_d   = GAPW'(MIN_GAP) + GAPW'(lfsr_q[GW-1:0]);
                    count_d = count_q + 16'd1;
                    pulse_d = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset overriding all other inputs.
    always_ff @(posedge clock) begin
        if (rst) begin
            active_q <= '0;
            x_q      <= '0;
            type_q   <= '0;
            pulse_q  <= 1'b0;
            count_q  <= 16'h0000;
            gap_q    <= GAPW'(MIN_GAP);
            lfsr_q   <= LFSR_INIT;
        end else begin
            active_q <= active_d;
            x_q      <= x_d;
            type_q   <= type_d;
            pulse_q  <= pulse_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
            lfsr_q   <= lfsr_d;
        end
    end

    assign obj_active  = active_q;
    assign obj_x       = x_q;
    assign obj_type    = type_q;
    assign spawn_pulse = pulse_q;
    assign spawn_count = count_q;

endmodule

// File: tb/tb_enemy_spawner.sv
// Directed bench for enemy_spawner with a reference LFSR for spawn types and gaps.
module tb_enemy_spawner;

    localparam int SLOTS = 4;
    localparam int XW    = 10;
    localparam int TW    = 2;

    logic                clock;
    logic                rst;
    logic                tick;
    logic                run;
    logic                clear;
    logic [3:0]          speed;
    logic [SLOTS-1:0]    obj_active;
    logic [SLOTS*XW-1:0] obj_x;
    logic [SLOTS*TW-1:0] obj_type;
    logic                spawn_pulse;
    logic [15:0]         spawn_count;

    int          n_checks;
    int          n_fail;
    int          exp_count;
    int          g;
    int          g1;
    logic [15:0] m_lfsr;

    enemy_spawner dut (
        .clock       (clock),
        .rst         (rst),
        .tick        (tick),
        .run         (run),
        .clear       (clear),
        .speed       (speed),
        .obj_active  (obj_active),
        .obj_x       (obj_x),
        .obj_type    (obj_type),
        .spawn_pulse (spawn_pulse),
        .spawn_count (spawn_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference Galois LFSR, seed 16'hACE1, mask 16'hB400, shifting every clock.
    always @(posedge clock) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given tick/clear, sampled 1 time unit after the edge.
    task automatic cyc(input logic t, input logic c);
        tick  = t;
        clear = c;
        @(posedge clock);
        #1;
        tick  = 1'b0;
        clear = 1'b0;
    endtask

    // Step until a spawn pulse; verify step count, landing slot, x, type and counter.
    task automatic spawn_wait(input int exp_n, input string tag, output int gap);
        int               n;
        int               s;
        logic [15:0]      l;
        logic [SLOTS-1:0] a;
        n = 0;
        l = 16'h0;
        a = '0;
        do begin
            a = obj_active;
            l = m_lfsr;
            cyc(1'b1, 1'b0);
            n++;
        end while (!spawn_pulse && n < 200);
        chk({tag, "_steps"}, n, exp_n);
        s = 0;
        for (int i = SLOTS - 1; i >= 0; i--) if (!a[i]) s = i;
        chk({tag, "_active"}, obj_active[s], 1'b1);
        chk({tag, "_x"}, obj_x[s*XW +: XW], 640);
        chk({tag, "_type"}, obj_type[s*TW +: TW], l[TW-1:0]);
        exp_count++;
        chk({tag, "_count"}, spawn_count, exp_count);
        gap = 40 + int'(l[5:0]);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_count = 0;
        rst   = 1'b1;
        tick  = 1'b0;
        run   = 1'b1;
        clear = 1'b0;
        speed = 4'd0;

        // Reset held for 3 cycles
        repeat (3) @(posedge clock);
        #1;
        rst = 1'b0;
        chk("rst_active", obj_active, 0);
        chk("rst_x", obj_x, 0);
        chk("rst_type", obj_type, 0);
        chk("rst_pulse", spawn_pulse, 0);
        chk("rst_count", spawn_count, 0);

        // First spawn on step 41 into slot 0
        spawn_wait(41, "first", g1);
        chk("first_vec", obj_active, 4'b0001);
        cyc(1'b0, 1'b0);
        chk("pulse_one_cycle", spawn_pulse, 0);

        // Movement and retire: 640 -15x42-> 10 -5-> 5 -3-> 2 -3-> retire
        speed = 4'd15;
        repeat (42) cyc(1'b1, 1'b0);
        chk("mv_x10", obj_x[0 +: XW], 10);
        speed = 4'd5;
        cyc(1'b1, 1'b0);
        chk("mv_x5", obj_x[0 +: XW], 5);
        speed = 4'd3;
        cyc(1'b1, 1'b0);
        chk("mv_x2", obj_x[0 +: XW], 2);
        chk("mv_live", obj_active[0], 1);
        cyc(1'b1, 1'b0);
        chk("retire_active", obj_active[0], 0);
        chk("retire_x", obj_x[0 +: XW], 0);
        if (g1 + 1 <= 44) exp_count++;
        chk("mv_count", spawn_count, exp_count);

        // Full pool: 4 spawns at speed 0, then pending spawn
        cyc(1'b0, 1'b1);
        chk("clr_active", obj_active, 0);
        speed = 4'd0;
        spawn_wait(41, "pool0", g);
        spawn_wait(g + 1, "pool1", g);
        spawn_wait(g + 1, "pool2", g);
        spawn_wait(g + 1, "pool3", g);
        chk("pool_full", obj_active, 4'b1111);
        repeat (g) cyc(1'b1, 1'b0);
        chk("pool_gap_done_pulse", spawn_pulse, 0);
        repeat (3) begin
            cyc(1'b1, 1'b0);
            chk("pending_pulse", spawn_pulse, 0);
            chk("pending_active", obj_active, 4'b1111);
            chk("pending_count", spawn_count, exp_count);
        end
        speed = 4'd15;
        repeat (42) cyc(1'b1, 1'b0);
        chk("pool_x10", obj_x[0 +: XW], 10);
        chk("pool_still_full", obj_active, 4'b1111);
        cyc(1'b1, 1'b0);
        chk("retire_all", obj_active, 4'b0000);
        chk("retire_no_pulse", spawn_pulse, 0);
        spawn_wait(1, "reuse", g);
        chk("reuse_vec", obj_active, 4'b0001);

        // Clear beats a simultaneous tick with 2 live slots
        speed = 4'd0;
        spawn_wait(g + 1, "second", g);
        chk("two_live", obj_active, 4'b0011);
        cyc(1'b1, 1'b1);
        chk("clr_tick_active", obj_active, 0);
        chk("clr_tick_x", obj_x, 0);
        chk("clr_tick_type", obj_type, 0);
        chk("clr_tick_pulse", spawn_pulse, 0);
        chk("clr_tick_count", spawn_count, exp_count);
        spawn_wait(41, "after_clr", g);

        // run=0 freezes slots; LFSR keeps running
        speed = 4'd3;
        repeat (2) cyc(1'b1, 1'b0);
        chk("frz_pre_x", obj_x, 40'd634);
        run = 1'b0;
        repeat (10) cyc(1'b1, 1'b0);
        chk("frz_active", obj_active, 4'b0001);
        chk("frz_x", obj_x, 40'd634);
        chk("frz_count", spawn_count, exp_count);
        chk("frz_pulse", spawn_pulse, 0);
        run = 1'b1;
        spawn_wait(g - 1, "post_frz", g);
        spawn_wait(g + 1, "post_frz2", g);
        chk("post_frz_vec", obj_active, 4'b0111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enemy_spawner.md
Name: enemy_spawner

Overview:
- Parametrised successor to the fixed single-output enemy-generation check in the dinosaur game.
- Owns a pool of SLOTS obstacle slots and decides when to spawn an obstacle using an LFSR-randomised gap.
- Advances all live obstacles leftward by a programmable speed and retires them at the left edge.
- Sits between the frequency divider (supplies the game-step tick) and the renderer/collision logic (consumes the packed slot state).

Parameters:
- SLOTS, 4, number of concurrent obstacle slots (1..8).
- XW, 10, x-coordinate width.
- SCREEN_X, 640, spawn x position (must be < 2^XW).
- TW, 2, obstacle type width (2^TW types).
- MIN_GAP, 40, minimum ticks between spawns.
- GW, 6, width of random gap addend (gap = MIN_GAP + lfsr[GW-1:0]).
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1.

Ports:
- clock  in  1  system clock; the single clock; all state on rising edge.
- rst  in  1  synchronous active-high reset.
- tick  in  1  game-step enable, one clock wide.
- run  in  1  game running; when 0, tick is ignored.
- clear  in  1  synchronous game-over/restart clear of slots.
- speed  in  4  pixels moved per tick.
- obj_active  out  SLOTS  per-slot live flag.
- obj_x  out  SLOTS*XW  packed x positions; slot i at [i*XW +: XW].
- obj_type  out  SLOTS*TW  packed types; slot i at [i*TW +: TW].
- spawn_pulse  out  1  one-clock pulse in the cycle after a spawn.
- spawn_count  out  16  total spawns, wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (rst=1 at an edge): obj_active=0, all obj_x=0, obj_type=0, spawn_pulse=0, spawn_count=0, gap_cnt=MIN_GAP, lfsr=SEED. rst overrides every other input.
- LFSR: 16-bit Galois, mask 16'hB400. Shifts every clock when rst=0, independent of tick/run/clear.
- Step condition: step = tick & run & ~clear.
- clear (rst=0): obj_active=0, obj_x=0, obj_type=0, gap_cnt=MIN_GAP. spawn_count and lfsr are untouched. clear beats a simultaneous tick.
- All outputs are registered; effects of a step are visible the cycle after the step cycle.
- Movement, all slots in parallel on step, using pre-step state:
  - active and x >= speed: x <= x - speed.
  - active and x < speed: active <= 0, x <= 0 (retire; never wraps negative).
  - speed=0: positions hold.
- Spawn/gap FSM, evaluated on step (states implied by gap_cnt):
  - COUNT (gap_cnt != 0): gap_cnt decrements.
  - READY (gap_cnt == 0) and a free slot exists in pre-step state: spawn into the lowest-index inactive slot.
    - That slot gets active=1, x=SCREEN_X, type=lfsr[TW-1:0] (current value).
    - gap_cnt <= MIN_GAP + lfsr[GW-1:0], computed in max(GW, width(MIN_GAP))+1 bits.
    - spawn_count increments; spawn_pulse=1 next cycle.
    - The spawned slot is not moved in its spawn step.
  - READY and no free slot: spawn is pending; gap_cnt holds 0 and the spawn is retried on the next step.
- A slot retiring in step N is not reusable until step N+1.
- spawn_pulse is 0 in every cycle not following a spawn.
- rst or clear mid-pending discards the pending spawn.
- Non-step cycles: only the LFSR changes.

Test Plan:
- Reset: hold rst 3 cycles, then release -> obj_active=0, spawn_count=0, spawn_pulse=0; the first 40 steps produce no spawn, and step 41 gives obj_active=4'b0001, obj_x[slot0]=640, spawn_pulse high for exactly 1 cycle, spawn_count=1.
- Movement/retire: speed=3, slot0 active at x=5 -> after next step x=2; following step obj_active[0]=0, x=0 (no wrap to 1023).
- Full pool: SLOTS=4, speed=0, force 4 spawns -> gap expires with all slots full, gap_cnt stays 0, no pulse; set speed=15 until slot0 retires -> spawn lands in slot0 on the step after retirement, not in the same step.
- Clear priority: assert clear and tick in the same cycle with 2 live slots -> obj_active=0, gap_cnt=40, spawn_count unchanged, no movement; the next spawn occurs on step 41 after clear.
- run=0 freeze: with slots live, run=0 and 10 ticks -> obj_x, obj_active and spawn_count unchanged; the LFSR sequence still advances (check against the reference model's 16'hACE1 sequence).
- Gap randomness: SEED=16'hACE1, GW=6 -> each reload equals 40 + lfsr[5:0] from the scoreboard model; all gaps fall in 40..103.
